inst_rom_loader: RTL and testbench

//  Responder end of the core's instruction-fetch interface (rom_ce/rom_addr -> rom_data): word-organised instruction store.

---
 rtl/inst_rom_loader_pkg.sv | 22 ++
 rtl/inst_rom_loader_mem.sv | 25 ++
 rtl/inst_rom_loader.sv | 195 +++++++++++++++++++
 tb/tb_inst_rom_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction store and its boot loader.
package inst_rom_loader_pkg;

    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic        CHIP_ENABLE = 1'b1;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LEN_HI = 3'd1,
        LD_LEN_LO = 3'd2,
        LD_DATA   = 3'd3,
        LD_CSUM   = 3'd4,
        LD_DONE   = 3'd5,
        LD_ERR    = 3'd6
    } ld_state_e;

    // States in which the loader is consuming stream bytes.
    function automatic logic ld_accepting(ld_state_e s);
        return (s == LD_LEN_HI) || (s == LD_LEN_LO) || (s == LD_DATA) || (s == LD_CSUM);
    endfunction

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Word-organised instruction store: synchronous write, asynchronous read.
// Contents are deliberately not reset so a partial load survives a reset.
module inst_rom_mem #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction store with boot-time byte-stream loader.
// Stream: LEN_HI, LEN_LO (big-endian word count N), then 4*N bytes, each
// word big-endian. Optional trailing checksum byte when INST_ROM_CHECKSUM_EN
// is defined (running 8-bit sum of all prior bytes plus this byte must be 0).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LD_IDLE   | no session since reset; waits for ld_start
// LD_LEN_HI | expecting high byte of word count
// LD_LEN_LO | expecting low byte of word count; range-checks N
// LD_DATA   | assembling bytes into words and writing the store
// LD_CSUM   | expecting checksum byte (checksum build only)
// LD_DONE   | last session completed; waits for ld_start
// LD_ERR    | last session failed; waits for ld_start
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rom_ce_i,
    input  logic [31:0]      rom_addr_i,
    output logic [31:0]      rom_data_o,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    output logic             ld_ready,
    output logic             load_busy,
    output logic             load_done,
    output logic             load_err,
    output logic [LEN_W-1:0] load_words
);

`ifdef INST_ROM_CHECKSUM_EN
    localparam ld_state_e AFTER_DATA = LD_CSUM;
`else
    localparam ld_state_e AFTER_DATA = LD_DONE;
`endif

    ld_state_e         state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [23:0]       asm_q, asm_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  words_q, words_d;
`ifdef INST_ROM_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              fire;
    logic [15:0]       hdr;
    logic [LEN_W-1:0]  words_inc;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              unused_addr_lsb;

    assign ld_ready   = ld_accepting(state_q);
    assign load_busy  = ld_accepting(state_q);
    assign load_done  = (state_q == LD_DONE);
    assign load_err   = (state_q == LD_ERR);
    assign load_words = words_q;

    assign fire      = ld_valid && ld_ready;
    assign hdr       = {len_hi_q, ld_data};
    assign words_inc = words_q + LEN_W'(1);

    // State and datapath registers; store contents live in the memory sub-block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LD_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            asm_q    <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            words_q  <= '0;
`ifdef INST_ROM_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            asm_q    <= asm_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            words_q  <= words_d;
`ifdef INST_ROM_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // Next-state logic: header parse, word assembly, store writes, checksum.
    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        asm_d     = asm_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        words_d   = words_q;
`ifdef INST_ROM_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        mem_we    = 1'b0;
        mem_wdata = {asm_q, ld_data};

        case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (ld_start) begin
                    state_d = LD_LEN_HI;
                    idx_d   = '0;
                    ptr_d   = '0;
                    words_d = '0;
`ifdef INST_ROM_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LD_LEN_HI: begin
                if (fire) begin
                    len_hi_d = ld_data;
`ifdef INST_ROM_CHECKSUM_EN
                    sum_d    = sum_q + ld_data;
`endif
                    state_d  = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (fire) begin
                    len_d = LEN_W'(hdr);
`ifdef INST_ROM_CHECKSUM_EN
                    sum_d = sum_q + ld_data;
`endif
                    // A count equal to the depth is legal; one more is not.
                    if (32'(hdr) > (32'd1 << ADDR_W)) begin
                        state_d = LD_ERR;
                    end else if (hdr == 16'd0) begin
                        state_d = AFTER_DATA;
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (fire) begin
`ifdef INST_ROM_CHECKSUM_EN
                    sum_d = sum_q + ld_data;
`endif
                    idx_d = idx_q + 2'd1;
                    asm_d = {asm_q[15:0], ld_data};
                    if (idx_q == 2'd3) begin
                        mem_we  = 1'b1;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        words_d = words_inc;
                        if (words_inc == len_q) begin
                            state_d = AFTER_DATA;
                        end
                    end
                end
            end
`ifdef INST_ROM_CHECKSUM_EN
            LD_CSUM: begin
                if (fire) begin
                    state_d = (8'(sum_q + ld_data) == 8'h00) ? LD_DONE : LD_ERR;
                end
            end
`endif
            default: state_d = LD_IDLE;
        endcase
    end

    inst_rom_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (ptr_q),
        .wdata_i (mem_wdata),
        .raddr_i (rom_addr_i[ADDR_W+1:2]),
        .rdata_o (mem_rdata)
    );

    // Byte offset within a word is irrelevant to a word-organised fetch.
    assign unused_addr_lsb = ^rom_addr_i[1:0];

    assign rom_data_o = ((rom_ce_i != CHIP_ENABLE) || load_busy || (|rom_addr_i[31:ADDR_W+2]))
                        ? ZERO_WORD : mem_rdata;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: scoreboard of written words,
// checked through the fetch port after each load session.
module tb_inst_rom_loader;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rom_ce_i = 1'b0;
    logic [31:0]       rom_addr_i = '0;
    logic [31:0]       rom_data_o;
    logic              ld_start = 1'b0;
    logic              ld_valid = 1'b0;
    logic [7:0]        ld_data = '0;
    logic              ld_ready;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic [LEN_W-1:0]  load_words;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;

    fetch_t      exp_q[$];
    logic [31:0] prog[$];
    logic [7:0]  sum_m;
    int          n_tests = 0;
    int          n_fail  = 0;

    inst_rom_loader #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .load_words (load_words)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fetch_chk(input string tag, input logic ce, input logic [31:0] addr,
                             input logic [31:0] exp);
        rom_ce_i   = ce;
        rom_addr_i = addr;
        #1;
        chk(tag, rom_data_o, exp);
        rom_ce_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    // Offer one byte and hold it until handshaken; optional idle cycle afterwards.
    task automatic send_byte(input logic [7:0] b, input bit gap, input bit restart);
        int n;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = b;
        n = 0;
        while (!ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ld_ready) chk("ready_timeout", 32'(ld_ready), 32'd1);
        @(posedge clk);
        sum_m = sum_m + b;
        if (gap) begin
            @(negedge clk);
            ld_valid = 1'b0;
            ld_data  = 8'($urandom);
            ld_start = restart;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (load_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic verify();
        fetch_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            fetch_chk("fetch", 1'b1, e.addr, e.data);
        end
    endtask

    // Full session for the words in prog; checks flags and then the scoreboard.
    task automatic run_load(input bit gap, input bit bad_csum, input int restart_word);
        logic [15:0] nn;
        logic [31:0] w;
        logic [7:0]  cs;
        nn    = 16'(prog.size());
        sum_m = 8'h00;
        pulse_start();
        chk("busy_start", 32'(load_busy), 32'd1);
        send_byte(nn[15:8], gap, 1'b0);
        send_byte(nn[7:0], gap, 1'b0);
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31-8*b -: 8], gap, (i == restart_word) && (b == 1));
            end
            exp_q.push_back('{32'(i * 4), w});
            if (i == 0 && prog.size() >= 2) begin
                #1;
                chk("busy_mid", 32'(load_busy), 32'd1);
                fetch_chk("fetch_gated", 1'b1, 32'h0, 32'h0);
            end
        end
`ifdef INST_ROM_CHECKSUM_EN
        cs = 8'(8'h00 - sum_m) + 8'(bad_csum);
        send_byte(cs, gap, 1'b0);
`else
        cs = 8'h00;
`endif
        @(negedge clk);
        ld_valid = 1'b0;
        ld_start = 1'b0;
        wait_idle();
        chk("busy_end", 32'(load_busy), 32'd0);
        chk("done", 32'(load_done), 32'(!bad_csum));
        chk("err", 32'(load_err), 32'(bad_csum));
        chk("words", 32'(load_words), 32'(nn));
        verify();
    endtask

    task automatic std_prog();
        prog.delete();
        prog.push_back(32'h2401_0010);
        prog.push_back(32'h3421_0020);
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_busy", 32'(load_busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_words", 32'(load_words), 32'd0);
        fetch_chk("rst_fetch_ce0", 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(ld_ready), 32'd0);

        // Basic two-word program
        std_prog();
        run_load(1'b0, 1'b0, -1);
        fetch_chk("ce_off", 1'b0, 32'h4, 32'h0);
        fetch_chk("out_of_range", 1'b1, 32'h0000_1000, 32'h0);
        fetch_chk("out_of_range_hi", 1'b1, 32'h8000_0000, 32'h0);
        fetch_chk("byte_offset", 1'b1, 32'h6, 32'h3421_0020);

        // Empty program
        prog.delete();
        run_load(1'b0, 1'b0, -1);

        // Oversized header: 0x0401 words
        sum_m = 8'h00;
        pulse_start();
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        @(negedge clk);
        ld_valid = 1'b0;
        wait_idle();
        chk("big_err", 32'(load_err), 32'd1);
        chk("big_done", 32'(load_done), 32'd0);
        chk("big_words", 32'(load_words), 32'd0);
        chk("big_busy", 32'(load_busy), 32'd0);

`ifdef INST_ROM_CHECKSUM_EN
        // Wrong checksum: words still written
        prog.delete();
        prog.push_back(32'hCAFE_F00D);
        prog.push_back(32'h1357_9BDF);
        run_load(1'b0, 1'b1, -1);
`endif

        // Gapped stream with a restart pulse mid-data
        std_prog();
        run_load(1'b1, 1'b0, 1);

        // Random short program
        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back($urandom);
        run_load(1'b0, 1'b0, -1);

        // Full-depth program
        prog.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) prog.push_back($urandom);
        run_load(1'b0, 1'b0, -1);
        fetch_chk("last_word", 1'b1, 32'h0000_0FFC, prog[(1 << ADDR_W) - 1]);

        // Reset after five data bytes
        sum_m = 8'h00;
        pulse_start();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'hDE, 1'b0, 1'b0);
        send_byte(8'hAD, 1'b0, 1'b0);
        send_byte(8'hBE, 1'b0, 1'b0);
        send_byte(8'hEF, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_ready", 32'(ld_ready), 32'd0);
        chk("arst_busy", 32'(load_busy), 32'd0);
        chk("arst_done", 32'(load_done), 32'd0);
        chk("arst_err", 32'(load_err), 32'd0);
        chk("arst_words", 32'(load_words), 32'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        fetch_chk("retained", 1'b1, 32'h0, 32'hDEAD_BEEF);
        std_prog();
        run_load(1'b0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
